// File: rtl/sqsum_decode.sv
// Sum-of-squares decoder: finds the smallest n with 1^2+..+n^2 >= target.
// Optional `sum` result port is enabled by defining SQSUM_DECODE_SUM_OUT_EN.
//
// state | meaning
// IDLE  | waiting for en; results from the last search are held
// RUN   | one candidate order checked per clock
// DONE  | results presented with valid for one cycle
module sqsum_decode #(
    parameter int MAX_N = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] target,
    output logic        busy,
    output logic        valid,
    output logic [3:0]  order,
    output logic        exact,
    output logic        overflow
`ifdef SQSUM_DECODE_SUM_OUT_EN
    ,
    output logic [10:0] sum
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] N_LAST = 4'(MAX_N);

    state_t      state;
    logic [3:0]  n;
    logic [10:0] acc;
    logic [10:0] tgt;
    // sq tracks (n+1)^2 so the next accumulation needs no multiplier
    logic [7:0]  sq;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            n        <= 4'd0;
            acc      <= 11'd0;
            tgt      <= 11'd0;
            sq       <= 8'd1;
            valid    <= 1'b0;
            order    <= 4'd0;
            exact    <= 1'b0;
            overflow <= 1'b0;
`ifdef SQSUM_DECODE_SUM_OUT_EN
            sum      <= 11'd0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        tgt      <= target;
                        n        <= 4'd0;
                        acc      <= 11'd0;
                        sq       <= 8'd1;
                        order    <= 4'd0;
                        exact    <= 1'b0;
                        overflow <= 1'b0;
`ifdef SQSUM_DECODE_SUM_OUT_EN
                        sum      <= 11'd0;
`endif
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (acc >= tgt) begin
                        order    <= n;
                        exact    <= (acc == tgt);
                        overflow <= 1'b0;
                        valid    <= 1'b1;
`ifdef SQSUM_DECODE_SUM_OUT_EN
                        sum      <= acc;
`endif
                        state    <= DONE;
                    end else if (n == N_LAST) begin
                        order    <= N_LAST;
                        exact    <= 1'b0;
                        overflow <= 1'b1;
                        valid    <= 1'b1;
`ifdef SQSUM_DECODE_SUM_OUT_EN
                        sum      <= acc;
`endif
                        state    <= DONE;
                    end else begin
                        n   <= n + 4'd1;
                        acc <= acc + {3'b000, sq};
                        // (n+2)^2 = (n+1)^2 + 2n + 3; the wrap after n=14 is never consumed
                        sq  <= sq + {3'b000, n, 1'b0} + 8'd3;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
